// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and state type for the seven-segment display controller
package display_pkg;

    localparam int SEG_W = 7;                           // segments per digit (g..a)
    localparam int NIB_W = 4;                           // bits per hex digit
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;     // low-active: all segments off

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT
    } disp_state_t;

endpackage

// File: rtl/hexto7seg.sv
// rtl/hexto7seg.sv - combinational hex nibble to low-active seven-segment decoder
//   hex_i : 4-bit hex digit
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = lit
module hexto7seg
    import display_pkg::*;
(
    input  logic [NIB_W-1:0] hex_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0011000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - sequences a multi-digit hex value through one shared decoder and commits all digits at once
//   clk, reset : system clock, synchronous active-high reset
//   in_valid/in_ready, in_value, lz_en : value handshake (lz_en = blank leading zeros)
//   hex_out    : low-active segments, digit k at [7k+6:7k]
//   done       : one-cycle pulse on the first cycle new hex_out is visible
//   busy       : high while a transfer is in flight
module hex_display_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIB_W*NUM_DIGITS-1:0] in_value,
    input  logic                        lz_en,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out,
    output logic                        done,
    output logic                        busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    disp_state_t                         state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NIB_W*NUM_DIGITS-1:0]         value_q, value_d;
    logic                                lz_q, lz_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]    shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]    hex_q, hex_d;
    logic                                done_q, done_d;

    logic [NIB_W-1:0]                    nib;
    logic [SEG_W-1:0]                    seg;

    // One decoder shared by all digits; idx selects which nibble it sees.
    assign nib = value_q[NIB_W*idx_q +: NIB_W];

    hexto7seg u_dec (
        .hex_i (nib),
        .seg_o (seg)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        value_d  = value_q;
        lz_d     = lz_q;
        shadow_d = shadow_q;
        hex_d    = hex_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    lz_d    = lz_en;
                    idx_d   = IDX_W'(NUM_DIGITS - 1);
                    state_d = DECODE;
                end
            end

            DECODE: begin
                // Walk from the MSD down; the first nonzero nibble ends blanking,
                // and digit 0 always shows so a zero value reads "0".
                if (lz_q && (nib == '0) && (idx_q != '0)) begin
                    shadow_d[idx_q] = SEG_BLANK;
                end else begin
                    shadow_d[idx_q] = seg;
                    lz_d            = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            COMMIT: begin
                // All digits update on the same edge, so no partial value is ever shown.
                hex_d   = shadow_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            value_q  <= '0;
            lz_q     <= 1'b0;
            shadow_q <= '1;
            hex_q    <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            lz_q     <= lz_d;
            shadow_q <= shadow_d;
            hex_q    <= hex_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign in_ready = !busy;
    assign hex_out  = hex_q;
    assign done     = done_q;

endmodule
